diamond_switch_actuator: RTL and testbench

Downstream stage of the switch-diamond interlocking logic. Consumes its four approach-signal requests (NW, SW, NE, SE) and its switch-set request, then drives the two coils of the bistable diamond switch motor with timed pulses. All signals are held at stop for the whole throw-and-settle window, so a train is never cleared across a moving switch.

---
 rtl/diamond_pkg.sv | 27 ++
 rtl/diamond_timer.sv | 42 ++++
 rtl/diamond_switch_actuator.sv | 108 ++++++++++
 tb/tb_diamond_switch_actuator.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/diamond_pkg.sv
// ============================================================================
// Module : diamond_pkg
// Brief  : Shared state encoding and signal bit indices for the switch diamond.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package diamond_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] PULSE  = 2'd2;
  localparam logic [1:0] SETTLE = 2'd3;

  localparam int SNW = 0;
  localparam int SSW = 1;
  localparam int SNE = 2;
  localparam int SSE = 3;

  // Returns {coil_set, coil_clr}; only one coil can ever be selected.
  function automatic logic [1:0] coil_decode(input logic [1:0] state, input logic target);
    coil_decode = (state == PULSE) ? {target, ~target} : 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/diamond_timer.sv
// ============================================================================
// Module : diamond_timer
// Brief  : Loadable down-counter that stops at zero and flags it.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module diamond_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/diamond_switch_actuator.sv
// ============================================================================
// Module : diamond_switch_actuator
// Brief  : Throws the bistable diamond switch with timed coil pulses while
//          holding every approach signal at stop.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module diamond_switch_actuator
  import diamond_pkg::*;
#(
  parameter int PULSE_CYCLES  = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sig_req,
  input  logic       set_req,
  output logic [3:0] sig_out,
  output logic       coil_set,
  output logic       coil_clr,
  output logic       sw_pos,
  output logic       busy
);

  localparam logic [CNT_W-1:0] c_PULSE_LD  = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);

  logic [1:0]       state_q,   state_d;
  logic             target_q,  target_d;
  logic             sw_pos_q,  sw_pos_d;
  logic [3:0]       sig_out_q, sig_out_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;

  diamond_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (tmr_load),
    .value_i (tmr_val),
    .zero_o  (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    sw_pos_d  = sw_pos_q;
    sig_out_d = '0;
    tmr_load  = 1'b0;
    tmr_val   = c_PULSE_LD;
    case (state_q)
      IDLE: begin
        if (set_req == sw_pos_q) begin
          sig_out_d = sig_req;
        end else begin
          target_d = set_req;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        state_d  = PULSE;
        sw_pos_d = target_q;
        tmr_load = 1'b1;
        tmr_val  = c_PULSE_LD;
      end
      PULSE: begin
        if (tmr_zero) begin
          state_d  = SETTLE;
          tmr_load = 1'b1;
          tmr_val  = c_SETTLE_LD;
        end
      end
      SETTLE: begin
        if (tmr_zero) begin
          state_d = IDLE;
        end
      end
      default: state_d = DRAIN;
    endcase
  end

  // Reset lands in DRAIN so the unknown physical position is homed to straight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DRAIN;
      target_q  <= 1'b0;
      sw_pos_q  <= 1'b0;
      sig_out_q <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      sw_pos_q  <= sw_pos_d;
      sig_out_q <= sig_out_d;
    end
  end

  assign {coil_set, coil_clr} = coil_decode(state_q, target_q);
  assign busy                 = (state_q != IDLE);
  assign sw_pos               = sw_pos_q;
  assign sig_out              = sig_out_q;

endmodule

`default_nettype wire

// File: tb/tb_diamond_switch_actuator.sv
// ============================================================================
// Module : tb_diamond_switch_actuator
// Brief  : Directed scoreboard bench for the diamond switch actuator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_diamond_switch_actuator;
  import diamond_pkg::*;

  localparam int P = 8;
  localparam int S = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] sig_req;
  logic       set_req;
  logic [3:0] sig_out;
  logic       coil_set;
  logic       coil_clr;
  logic       sw_pos;
  logic       busy;

  diamond_switch_actuator #(
    .PULSE_CYCLES  (P),
    .SETTLE_CYCLES (S),
    .CNT_W         (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sig_req  (sig_req),
    .set_req  (set_req),
    .sig_out  (sig_out),
    .coil_set (coil_set),
    .coil_clr (coil_clr),
    .sw_pos   (sw_pos),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] exp;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   ecnt  = 0;
  int   t;

  // Edge number since the most recent reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt = 0;
    else        ecnt = ecnt + 1;
  end

  function automatic logic [7:0] obs();
    return {sig_out, coil_set, coil_clr, sw_pos, busy};
  endfunction

  task automatic check(input string tag, input logic [7:0] o, input logic [7:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  task automatic push(input int k, input logic [7:0] e, input string tag);
    exp_t x;
    x.cyc = k;
    x.exp = e;
    x.tag = tag;
    sb.push_back(x);
  endtask

  // Expected outputs after edges t+1..kmax of a throw whose request changed just after edge t.
  task automatic throw_exp(input int t0, input logic tgt, input logic swp, input int kmax,
                           input logic [3:0] after, input string tag);
    logic w;
    for (int k = (t0 + 1 < 1) ? 1 : t0 + 1; k <= kmax; k++) begin
      w = (k >= t0 + 2) && (k <= t0 + 1 + P);
      push(k, {(k >= t0 + 3 + P + S) ? after : 4'd0, tgt & w, ~tgt & w,
               (k >= t0 + 2) ? tgt : swp, (k < t0 + 2 + P + S)}, tag);
    end
  endtask

  task automatic wait_until(input int k);
    for (int n = 0; n < 400 && ecnt < k; n++) begin
      @(posedge clk);
      #1;
    end
    tests++;
    assert (ecnt >= k) else begin
      fails++;
      $error("FAIL timeout: reached edge %0d needed %0d", ecnt, k);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("inv_coils", {7'd0, coil_set & coil_clr}, 8'd0);
      check("inv_stop_busy", {4'd0, busy ? sig_out : 4'd0}, 8'd0);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == ecnt) begin
          check($sformatf("%s@%0d", sb[i].tag, ecnt), obs(), sb[i].exp);
          sb.delete(i);
        end
      end
    end
  end

  initial begin
    sig_req = 4'b1 << SNW;
    set_req = 1'b0;
    #1 rst_n = 1'b0;
    #2 check("reset_state", obs(), 8'b0000_0001);

    // Homing throw after reset release.
    throw_exp(-1, 1'b0, 1'b0, 26, 4'b0001, "home");
    #9 rst_n = 1'b1;
    wait_until(26);

    // Plain signal pass-through in IDLE.
    t = ecnt;
    sig_req = 4'b1 << SNE;
    push(t + 1, 8'b0100_0000, "idle_sig");
    push(t + 2, 8'b0100_0000, "idle_sig");
    wait_until(t + 2);

    // Throw to set, reversed mid-pulse: two full throws back to back.
    t = ecnt;
    sig_req = 4'b1 << SSE;
    set_req = 1'b1;
    throw_exp(t, 1'b1, 1'b0, t + 26, 4'b0000, "rev1");
    throw_exp(t + 26, 1'b0, 1'b1, t + 53, 4'b1000, "rev2");
    wait_until(t + 5);
    set_req = 1'b0;
    wait_until(t + 53);

    // Clean throw to set.
    t = ecnt;
    set_req = 1'b1;
    throw_exp(t, 1'b1, 1'b0, t + 27, 4'b1000, "set");
    wait_until(t + 27);

    // Clean throw back to straight.
    t = ecnt;
    set_req = 1'b0;
    sig_req = 4'b1 << SSW;
    throw_exp(t, 1'b0, 1'b1, t + 27, 4'b0010, "clr");
    wait_until(t + 27);

    // One-cycle set_req glitch still throws fully, then throws back.
    t = ecnt;
    set_req = 1'b1;
    throw_exp(t, 1'b1, 1'b0, t + 26, 4'b0000, "glitch");
    throw_exp(t + 26, 1'b0, 1'b1, t + 53, 4'b0010, "unglitch");
    wait_until(t + 1);
    set_req = 1'b0;
    wait_until(t + 53);

    // Reset asserted mid-pulse, then a fresh homing throw.
    t = ecnt;
    set_req = 1'b1;
    sig_req = 4'b0001;
    throw_exp(t, 1'b1, 1'b0, t + 4, 4'b0000, "pre_rst");
    wait_until(t + 4);
    #6 rst_n = 1'b0;
    #1 check("async_rst", obs(), 8'b0000_0001);
    set_req = 1'b0;
    throw_exp(-1, 1'b0, 1'b0, 26, 4'b0001, "rehome");
    @(posedge clk);
    @(posedge clk);
    #4 rst_n = 1'b1;
    wait_until(26);

    repeat (3) @(posedge clk);
    #1;
    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL sb_drain: observed %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
